hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard and next-PC controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Drives the PC register's next-address, stall and redirect inputs (din, data_hazard, control_hazard).
- Drives the IF/ID and ID/EX flush lines.
- Keeps an internal scoreboard of in-flight destination registers in the EX, MEM and WB slots, advanced every clock, to detect RAW hazards.

Parameters:
- CNT_W, 16, width of the saturating performance counters stall_cnt and flush_cnt.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pc  in  32  current PC register value
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_re1  in  1  ID instruction reads rs1
- id_re2  in  1  ID instruction reads rs2
- id_rd  in  5  ID destination register
- id_we  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- ex_br_taken  in  1  branch/jump in EX resolved taken
- ex_br_target  in  32  resolved target address
- npc  out  32  next PC, connects to PC din
- data_hazard  out  1  stall request to PC and IF/ID
- control_hazard  out  1  redirect request to PC
- flush_ifid  out  1  clear IF/ID this edge
- flush_idex  out  1  insert bubble into ID/EX this edge
- stall_cnt  out  CNT_W  count of data_hazard cycles
- flush_cnt  out  CNT_W  count of control_hazard cycles

Behaviour:
- Reset: all scoreboard slots (EX, MEM, WB) are invalid. stall_cnt = flush_cnt = 0. Asynchronous clear is effective immediately, including mid-stall or mid-redirect.
- Scoreboard slot contents: valid, rd, we, is_load.
- Scoreboard advance on each rising edge: WB<=MEM; MEM<=EX; EX<=ID fields when id_valid && !flush_idex, else bubble (valid=0).
- Slot match: slot valid && we && rd!=0 && rd equals a read-enabled source (rs1 with re1, rs2 with re2).
  - Register x0 never matches.
- Raw RAW condition: id_valid && any qualifying slot match (slot set depends on FORWARD_EN, below).
- ctrl: ex_br_taken && EX slot valid.
  - ex_br_taken while the EX slot is a bubble is ignored.
- control_hazard = ctrl.
- data_hazard = raw RAW && !ctrl.
  - Redirect has priority: the instructions being stalled are squashed anyway.
- npc = ctrl ? ex_br_target : pc + 32'd4. Addition wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- flush_ifid = ctrl.
- flush_idex = ctrl | data_hazard.
- Latency: all hazard outputs are combinational from the current inputs and registered scoreboard; no added cycles.
  - A taken branch costs 2 bubbles (IF/ID and ID/EX flushed).
  - During a data stall the PC and IF/ID hold while ID/EX receives a bubble. The stall releases on the first cycle the matching producer no longer satisfies the condition.
- Counters: stall_cnt += 1 per cycle data_hazard=1; flush_cnt += 1 per cycle control_hazard=1. Both saturate at all-ones, no wrap.
- No state machine beyond the scoreboard shift; the design has no deadlock (every stall is bounded by producer drain, at most 3 cycles).

Optional Feature:
- Macro FORWARD_EN.
- Defined: the EX/MEM/WB forwarding network exists. RAW stalls only on a load-use, i.e. EX slot match with is_load=1; MEM and WB matches are ignored. Max stall is 1 cycle.
- Undefined: no forwarding. A match in any of EX, MEM or WB stalls. The register file writes on the clock edge, so a WB match still stalls 1 cycle. Max stall is 3 cycles.

Test Plan:
- Reset: assert rst mid-stall -> data_hazard=0, control_hazard=0, stall_cnt=0; after release with pc=0x100, npc=0x104.
- Load-use: lw x5 then add x6,x5,x7 (FORWARD_EN) -> data_hazard=1 for exactly 1 cycle, flush_idex=1, stall_cnt=1; the add proceeds next cycle.
- ALU RAW without FORWARD_EN: add x5 then sub x8,x5,x1 -> data_hazard high for 3 cycles; with FORWARD_EN -> 0 cycles.
- x0 writer: addi x0,.. followed by a reader of x0 -> data_hazard never asserted in either build.
- Taken branch: ex_br_taken=1, target=0x200 with EX valid -> control_hazard=1, npc=0x200, flush_ifid=flush_idex=1, flush_cnt +1. The same pulse with the EX slot a bubble -> no redirect, npc=pc+4.
- Simultaneous load-use and taken branch: control_hazard=1, data_hazard=0, npc=target. Separately, pc=0xFFFFFFFC with no hazard -> npc=0x00000000.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW/redirect hazard detection and next-PC select.
// Build option: define FORWARD_EN when the EX/MEM/WB bypass network exists.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_br_target,
  output logic [31:0]      npc,
  output logic             data_hazard,
  output logic             control_hazard,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

`ifdef FORWARD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

  logic       ex_v, mem_v, wb_v;
  logic       ex_we, mem_we, wb_we;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_ld;

  logic ex_hit, mem_hit, wb_hit;
  logic raw, ctrl;

  function automatic logic hit(
    input logic       v,
    input logic       we,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       re1,
    input logic       re2
  );
    return v && we && (rd != 5'd0) &&
           ((re1 && rd == rs1) || (re2 && rd == rs2));
  endfunction

  // Source match against each in-flight producer, then hazard priority.
  always_comb begin
    ex_hit  = hit(ex_v, ex_we, ex_rd,
                  id_rs1, id_rs2, id_re1, id_re2);
    mem_hit = hit(mem_v, mem_we, mem_rd,
                  id_rs1, id_rs2, id_re1, id_re2);
    wb_hit  = hit(wb_v, wb_we, wb_rd,
                  id_rs1, id_rs2, id_re1, id_re2);
    // With bypassing only a load in EX cannot be forwarded in time.
    raw = id_valid &&
          ((ex_hit && (ex_ld || !FWD)) ||
           (!FWD && (mem_hit || wb_hit)));
    ctrl           = ex_br_taken && ex_v;
    control_hazard = ctrl;
    data_hazard    = raw && !ctrl;
    flush_ifid     = ctrl;
    flush_idex     = ctrl || data_hazard;
    npc            = ctrl ? ex_br_target : pc + 32'd4;
  end

  // Scoreboard shift: ID enters EX unless squashed or stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v   <= 1'b0;
      mem_v  <= 1'b0;
      wb_v   <= 1'b0;
      ex_we  <= 1'b0;
      mem_we <= 1'b0;
      wb_we  <= 1'b0;
      ex_rd  <= 5'd0;
      mem_rd <= 5'd0;
      wb_rd  <= 5'd0;
      ex_ld  <= 1'b0;
    end else begin
      wb_v   <= mem_v;
      wb_we  <= mem_we;
      wb_rd  <= mem_rd;
      mem_v  <= ex_v;
      mem_we <= ex_we;
      mem_rd <= ex_rd;
      ex_v   <= id_valid && !flush_idex;
      ex_we  <= id_we;
      ex_rd  <= id_rd;
      ex_ld  <= id_is_load;
    end
  end

  // Saturating stall/redirect performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (data_hazard && stall_cnt != SAT)
        stall_cnt <= stall_cnt + ONE;
      if (control_hazard && flush_cnt != SAT)
        flush_cnt <= flush_cnt + ONE;
    end
  end

endmodule
